// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: frame-width default and FSM state type.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection
// on the synchronized value against its previous-cycle copy.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    // Shift the pin through the chain; reset parks it at the pin's idle level.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_chain <= {STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
        end else begin
            r_chain <= (r_chain << 1) | STAGES'(i_async);
            r_prev  <= r_chain[STAGES-1];
        end
    end

    // Edge pulses are one clk cycle wide.
    always_comb begin
        o_sync = r_chain[STAGES-1];
        o_rise = o_sync & ~r_prev;
        o_fall = ~o_sync & r_prev;
    end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with a single-word transmit holding register.
// Bit order: MSB first by default; define SPI_SLAVE_LSB_FIRST_EN for LSB first.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    spi_state_e        r_state;
    spi_state_e        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic              r_skip_fall;

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_edges;

    logic              w_start, w_abort, w_rise, w_fall, w_last, w_load, w_wr;
    logic [DATA_W-1:0] w_load_word, w_rx_next, w_tx_next;
    logic              w_tx_bit;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (SCLK),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (SS),
        .o_sync  (w_ss_sync),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (MOSI),
        .o_sync  (w_mosi),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    // Only edges of SCLK/SS and the level of MOSI drive the design.
    assign w_unused_edges = ^{w_sclk_sync, w_ss_sync, w_mosi_rise, w_mosi_fall};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: frame boundaries follow the synchronized SS edges.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_next = ACTIVE;
            ACTIVE:  if (w_ss_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: MISO is only driven while selected.
    always_comb begin
        busy     = (r_state == ACTIVE);
        MISO_oe  = (r_state == ACTIVE);
        MISO     = (r_state == ACTIVE) ? w_tx_bit : 1'b0;
        tx_ready = ~r_hold_full;
        rx_data  = r_rx_data;
        rx_valid = r_rx_valid;
    end

    // Datapath control decode; SS release takes priority over a coincident SCLK edge.
    always_comb begin
        w_start     = (r_state == IDLE) && w_ss_fall;
        w_abort     = (r_state == ACTIVE) && w_ss_rise;
        w_rise      = (r_state == ACTIVE) && !w_ss_rise && w_sclk_rise;
        w_fall      = (r_state == ACTIVE) && !w_ss_rise && w_sclk_fall;
        w_last      = w_rise && (r_cnt == CNT_LAST);
        w_load      = w_start || w_last;
        // A load always sees the pre-write holding state, so a same-cycle write waits.
        w_load_word = r_hold_full ? r_hold : '1;
        w_wr        = tx_valid && !r_hold_full;
`ifdef SPI_SLAVE_LSB_FIRST_EN
        w_rx_next   = {w_mosi, r_rx_shift[DATA_W-1:1]};
        w_tx_next   = {1'b0, r_tx_shift[DATA_W-1:1]};
        w_tx_bit    = r_tx_shift[0];
`else
        w_rx_next   = {r_rx_shift[DATA_W-2:0], w_mosi};
        w_tx_next   = {r_tx_shift[DATA_W-2:0], 1'b0};
        w_tx_bit    = r_tx_shift[DATA_W-1];
`endif
    end

    // Shift registers, bit counter, received word and holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_skip_fall <= 1'b0;
        end else begin
            r_rx_valid <= w_last;
            if (w_last) begin
                r_rx_data <= w_rx_next;
            end

            if (w_start || w_abort) begin
                r_cnt      <= '0;
                r_rx_shift <= '0;
            end else if (w_rise) begin
                r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
                r_rx_shift <= w_rx_next;
            end

            if (w_load) begin
                r_tx_shift <= w_load_word;
            end else if (w_fall && !r_skip_fall) begin
                r_tx_shift <= w_tx_next;
            end

            // After a back-to-back reload the next falling edge keeps the new first bit.
            if (w_start) begin
                r_skip_fall <= 1'b0;
            end else if (w_last) begin
                r_skip_fall <= 1'b1;
            end else if (w_fall) begin
                r_skip_fall <= 1'b0;
            end

            if (w_wr) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

endmodule
